chunk_serial_adder: RTL and testbench

Multi-cycle, parametrised add/subtract unit that generalises the 16-bit combinational ripple adder. Each clock cycle it processes a CHUNK-bit slice of a WIDTH-bit operand pair through one small ripple adder, carrying between slices in a register. Operation uses a start/done handshake. The unit sits beside the datapath wherever a full-width combinational carry chain is too long for the clock period.

---
 rtl/chunk_serial_adder.sv | 137 +++++++++++++
 tb/tb_chunk_serial_adder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/subtract unit: a WIDTH-bit operand pair is summed CHUNK bits per clock
// through one small ripple adder, with the inter-chunk carry held in a register.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_ext;
  logic             carry;
  logic             sign_a;
  logic             sign_b;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             last;
  logic [CHUNK:0]   chunk_res;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // New chunk sum enters the result register from the top, so after N steps
  // the first (least-significant) chunk has drifted down to bit 0.
  always_comb begin
    chunk_res = chunk_add(a_reg[CHUNK-1:0], b_reg[CHUNK-1:0], carry);
    sum_ext   = '0;
    sum_ext[CHUNK-1:0] = chunk_res[CHUNK-1:0];
    acc_next  = (acc >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_reg  <= a;
      b_reg  <= sub ? ~b : b;
      acc    <= '0;
      carry  <= cin ^ sub;
      sign_a <= a[WIDTH-1];
      sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      cnt    <= '0;
    end else if (step) begin
      a_reg  <= a_reg >> CHUNK;
      b_reg  <= b_reg >> CHUNK;
      acc    <= acc_next;
      carry  <= chunk_res[CHUNK];
      cnt    <= cnt + 1'b1;
    end
  end

  // Visible results move only on the completion edge and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        s    <= acc_next;
        cout <= chunk_res[CHUNK];
        ovf  <= (sign_a == sign_b) && (acc_next[WIDTH-1] != sign_a);
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder at 16/4, 8/8 and 32/8 configurations.
module tb_chunk_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic        busy16, done16, cout16, ovf16;

  logic        start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        busy8, done8, cout8, ovf8;

  logic        start32 = 0, sub32 = 0, cin32 = 0;
  logic [31:0] a32 = 0, b32 = 0, s32;
  logic        busy32, done32, cout32, ovf32;

  int checks = 0;
  int errors = 0;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16));

  chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));

  chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32));

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : (w == 32) ? done32 : done16;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : (w == 32) ? busy32 : busy16;
  endfunction

  task automatic drive(input int w, input logic st, input logic op_sub,
                       input logic [31:0] op_a, input logic [31:0] op_b, input logic op_cin);
    case (w)
      8:  begin start8  = st; sub8  = op_sub; a8  = op_a[7:0];  b8  = op_b[7:0];  cin8  = op_cin; end
      32: begin start32 = st; sub32 = op_sub; a32 = op_a;       b32 = op_b;       cin32 = op_cin; end
      default: begin start16 = st; sub16 = op_sub; a16 = op_a[15:0]; b16 = op_b[15:0]; cin16 = op_cin; end
    endcase
  endtask

  // Issues one operation and waits (bounded) for done. lat counts edges from the
  // edge that samples start to the edge after which done is seen.
  task automatic run_op(input int w, input logic op_sub, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic op_cin,
                        output logic [31:0] rs, output logic rc, output logic ro,
                        output int lat, output int busy_cycles);
    drive(w, 1'b1, op_sub, op_a, op_b, op_cin);
    @(posedge clk); #1;
    drive(w, 1'b0, op_sub, op_a, op_b, op_cin);
    lat = 1;
    busy_cycles = 0;
    while (!get_done(w) && lat < 40) begin
      if (get_busy(w)) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    case (w)
      8:  begin rs = {24'd0, s8};  rc = cout8;  ro = ovf8;  end
      32: begin rs = s32;          rc = cout32; ro = ovf32; end
      default: begin rs = {16'd0, s16}; rc = cout16; ro = ovf16; end
    endcase
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({busy16, done16, cout16, ovf16} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl got %b exp 0000", {busy16, done16, cout16, ovf16}); end
    checks++; if (s16 !== 16'h0000) begin errors++; $display("FAIL reset_s got %h exp 0000", s16); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    logic [31:0] rs; logic rc, ro; int lat, bc;
    run_op(16, 1'b0, 32'hF04E, 32'hBCA9, 1'b1, rs, rc, ro, lat, bc);
    checks++; if (rs !== 32'hACF8) begin errors++; $display("FAIL add_s got %h exp acf8", rs); end
    checks++; if ({rc, ro} !== 2'b10) begin errors++; $display("FAIL add_cout_ovf got %b exp 10", {rc, ro}); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency got %0d exp 5", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d exp 4", bc); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL add_busy_at_done got %b exp 0", busy16); end
    @(posedge clk); #1;
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b exp 0", done16); end
    checks++; if (s16 !== 16'hACF8) begin errors++; $display("FAIL add_s_hold got %h exp acf8", s16); end
  endtask

  task automatic test_overflow();
    logic [31:0] rs; logic rc, ro; int lat, bc;
    run_op(16, 1'b0, 32'h7FFF, 32'h0001, 1'b0, rs, rc, ro, lat, bc);
    checks++; if (rs !== 32'h8000) begin errors++; $display("FAIL ovf_add_s got %h exp 8000", rs); end
    checks++; if ({rc, ro} !== 2'b01) begin errors++; $display("FAIL ovf_add_flags got %b exp 01", {rc, ro}); end
    run_op(16, 1'b1, 32'h8000, 32'h0001, 1'b0, rs, rc, ro, lat, bc);
    checks++; if (rs !== 32'h7FFF) begin errors++; $display("FAIL ovf_sub_s got %h exp 7fff", rs); end
    checks++; if ({rc, ro} !== 2'b11) begin errors++; $display("FAIL ovf_sub_flags got %b exp 11", {rc, ro}); end
  endtask

  task automatic test_subtract();
    logic [31:0] rs; logic rc, ro; int lat, bc;
    run_op(16, 1'b1, 32'h0000, 32'h0001, 1'b0, rs, rc, ro, lat, bc);
    checks++; if (rs !== 32'hFFFF) begin errors++; $display("FAIL sub_borrow_s got %h exp ffff", rs); end
    checks++; if ({rc, ro} !== 2'b00) begin errors++; $display("FAIL sub_borrow_flags got %b exp 00", {rc, ro}); end
    run_op(16, 1'b1, 32'h0005, 32'h0003, 1'b1, rs, rc, ro, lat, bc);
    checks++; if (rs !== 32'h0001) begin errors++; $display("FAIL sub_bin_s got %h exp 0001", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub_bin_cout got %b exp 1", rc); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    drive(16, 1'b1, 1'b0, 32'h1234, 32'h1111, 1'b0);
    @(posedge clk); #1;
    drive(16, 1'b0, 1'b0, 32'h1234, 32'h1111, 1'b0);
    lat = 1;
    while (!done16 && lat < 40) begin
      if (lat == 2) drive(16, 1'b1, 1'b0, 32'hFFFF, 32'h1111, 1'b0);
      @(posedge clk); #1;
      lat++;
      start16 = 1'b0;
    end
    checks++; if (s16 !== 16'h2345) begin errors++; $display("FAIL busy_ignore_s got %h exp 2345", s16); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL busy_ignore_latency got %0d exp 5", lat); end
    // Issue the next operation in the done cycle itself.
    drive(16, 1'b1, 1'b0, 32'h0100, 32'h0023, 1'b0);
    @(posedge clk); #1;
    drive(16, 1'b0, 1'b0, 32'h0000, 32'h0000, 1'b0);
    checks++; if ({busy16, done16} !== 2'b10) begin errors++;
      $display("FAIL b2b_accept got busy/done %b exp 10", {busy16, done16}); end
    lat = 1;
    while (!done16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency got %0d exp 5", lat); end
    checks++; if (s16 !== 16'h0123) begin errors++; $display("FAIL b2b_s got %h exp 0123", s16); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done16) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL b2b_no_queue got %0d pulses exp 0", pulses); end
  endtask

  task automatic test_abort();
    logic [31:0] rs; logic rc, ro; int lat, bc, pulses;
    drive(16, 1'b1, 1'b0, 32'hFFFF, 32'hFFFF, 1'b1);
    @(posedge clk); #1;
    drive(16, 1'b0, 1'b0, 32'h0000, 32'h0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy16, done16, cout16, ovf16} !== 4'b0000) begin errors++;
      $display("FAIL abort_ctrl got %b exp 0000", {busy16, done16, cout16, ovf16}); end
    checks++; if (s16 !== 16'h0000) begin errors++; $display("FAIL abort_s got %h exp 0000", s16); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", pulses); end
    run_op(16, 1'b0, 32'h1234, 32'h4321, 1'b0, rs, rc, ro, lat, bc);
    checks++; if (rs !== 32'h5555) begin errors++; $display("FAIL abort_next_s got %h exp 5555", rs); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL abort_next_latency got %0d exp 5", lat); end
  endtask

  task automatic test_width8();
    logic [31:0] rs; logic rc, ro; int lat, bc;
    run_op(8, 1'b0, 32'hFF, 32'h01, 1'b0, rs, rc, ro, lat, bc);
    checks++; if (rs !== 32'h00) begin errors++; $display("FAIL w8_s got %h exp 00", rs); end
    checks++; if ({rc, ro} !== 2'b10) begin errors++; $display("FAIL w8_flags got %b exp 10", {rc, ro}); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL w8_latency got %0d exp 2", lat); end
  endtask

  task automatic test_width32();
    logic [31:0] rs, va, vb; logic rc, ro, vc; int lat, bc;
    logic [32:0] exp_sum;
    for (int i = 0; i < 4; i++) begin
      va = $urandom; vb = $urandom; vc = 1'($urandom_range(0, 1));
      if (i == 0) begin va = 32'hFFFF_FFFF; vb = 32'h0000_0001; vc = 1'b0; end
      exp_sum = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
      run_op(32, 1'b0, va, vb, vc, rs, rc, ro, lat, bc);
      checks++; if ({rc, rs} !== exp_sum) begin errors++;
        $display("FAIL w32_sum[%0d] got %h exp %h", i, {rc, rs}, exp_sum); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL w32_latency[%0d] got %0d exp 5", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_abort();
    test_width8();
    test_width32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
